// File: rtl/timing_gen.sv
// timing_gen: beat/phase timing generator for the hardwired controller.
// Produces one-hot beat levels W1..W3 and phase levels T1..T3, and reacts to
// the controller's short/long/stop requests at each beat boundary.
// Optional single-cycle stepping is compiled in with `define TIMING_STEP_EN
// (adds the `step` input).
module timing_gen #(
  parameter int PH_LEN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic qd,
  input  logic short,
  input  logic long,
  input  logic stop,
`ifdef TIMING_STEP_EN
  input  logic step,
`endif
  output logic w1,
  output logic w2,
  output logic w3,
  output logic t1,
  output logic t2,
  output logic t3,
  output logic running,
  output logic cyc_end
);

  localparam int CW = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PH_LEN - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;
  typedef enum logic [1:0] {B_W1 = 2'd0, B_W2 = 2'd1, B_W3 = 2'd2} beat_t;
  typedef enum logic [1:0] {P_T1 = 2'd0, P_T2 = 2'd1, P_T3 = 2'd2} phase_t;

  state_t          state, state_nx;
  beat_t           beat, beat_nx, follow_s;
  phase_t          phase, phase_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            step_s;
  logic            cyc_end_nx;

`ifdef TIMING_STEP_EN
  assign step_s = step;
`else
  assign step_s = 1'b0;
`endif

  // Beat that follows b at a beat boundary; short only counts in W1, long only in W2.
  function automatic beat_t follow_beat(input beat_t b, input logic sh, input logic lg);
    case (b)
      B_W1:    follow_beat = sh ? B_W1 : B_W2;
      B_W2:    follow_beat = lg ? B_W3 : B_W1;
      default: follow_beat = B_W1;
    endcase
  endfunction

  // One-hot {w1,w2,w3} for a beat.
  function automatic logic [2:0] beat_onehot(input beat_t b);
    case (b)
      B_W1:    beat_onehot = 3'b100;
      B_W2:    beat_onehot = 3'b010;
      B_W3:    beat_onehot = 3'b001;
      default: beat_onehot = 3'b000;
    endcase
  endfunction

  // One-hot {t1,t2,t3} for a phase.
  function automatic logic [2:0] phase_onehot(input phase_t p);
    case (p)
      P_T1:    phase_onehot = 3'b100;
      P_T2:    phase_onehot = 3'b010;
      P_T3:    phase_onehot = 3'b001;
      default: phase_onehot = 3'b000;
    endcase
  endfunction

  assign follow_s = follow_beat(beat, short, long);

  // Next-state logic: phase sub-counter, phase rotation and beat-boundary decisions.
  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    phase_nx = phase;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (qd) begin
          state_nx = S_RUN;
          beat_nx  = B_W1;
          phase_nx = P_T1;
          cnt_nx   = '0;
        end else begin
          beat_nx  = B_W1;
        end
      end
      S_RUN: begin
        if (cnt != CNT_LAST) begin
          cnt_nx = cnt + CW'(1);
        end else begin
          cnt_nx = '0;
          case (phase)
            P_T1: phase_nx = P_T2;
            P_T2: phase_nx = P_T3;
            default: begin
              // Beat boundary: advance the beat even when halting so HALT shows the pending beat.
              phase_nx = P_T1;
              beat_nx  = follow_s;
              if (stop || (step_s && (follow_s == B_W1))) begin
                state_nx = S_HALT;
              end else begin
                state_nx = S_RUN;
              end
            end
          endcase
        end
      end
      S_HALT: begin
        if (qd) begin
          state_nx = S_RUN;
          phase_nx = P_T1;
          cnt_nx   = '0;
        end else begin
          state_nx = S_HALT;
        end
      end
      default: begin
        state_nx = S_IDLE;
        beat_nx  = B_W1;
        phase_nx = P_T1;
        cnt_nx   = '0;
      end
    endcase
  end

  // cyc_end is registered, so it is raised on entry to the boundary clock whose
  // successor beat is W1; short/long are expected to hold steady through a beat.
  always_comb begin
    if ((state_nx == S_RUN) && (phase_nx == P_T3) && (cnt_nx == CNT_LAST)) begin
      cyc_end_nx = (follow_beat(beat_nx, short, long) == B_W1);
    end else begin
      cyc_end_nx = 1'b0;
    end
  end

  // State registers and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      beat         <= B_W1;
      phase        <= P_T1;
      cnt          <= '0;
      {w1, w2, w3} <= 3'b000;
      {t1, t2, t3} <= 3'b000;
      running      <= 1'b0;
      cyc_end      <= 1'b0;
    end else begin
      state        <= state_nx;
      beat         <= beat_nx;
      phase        <= phase_nx;
      cnt          <= cnt_nx;
      {w1, w2, w3} <= (state_nx != S_IDLE) ? beat_onehot(beat_nx) : 3'b000;
      {t1, t2, t3} <= (state_nx == S_RUN) ? phase_onehot(phase_nx) : 3'b000;
      running      <= (state_nx == S_RUN);
      cyc_end      <= cyc_end_nx;
    end
  end

endmodule

// File: doc/timing_gen.md
# timing_gen

Beat/phase timing generator for the hardwired controller. Produces the W1/W2/W3 beat levels and T1/T2/T3 phase pulses that the controller decodes. Consumes the controller's `short`, `long` and `stop` requests to shorten, lengthen or halt the machine cycle. Sits directly upstream of the controller and is started and resumed by the front-panel start pulse `qd`.

## Interface
- `PH_LEN`, default 1: clk cycles per phase (≥1); one beat = 3·PH_LEN clocks.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `qd` input 1: start/continue request, level-sampled; a one-clock pulse is enough.
- `short` input 1: from controller; end the machine cycle after W1.
- `long` input 1: from controller; extend the machine cycle to W3.
- `stop` input 1: from controller; halt after the current beat.
- `w1`, `w2`, `w3` output 1 each: one-hot beat level, or the pending beat while halted.
- `t1`, `t2`, `t3` output 1 each: one-hot phase level, all 0 when not running.
- `running` output 1: state is RUN.
- `cyc_end` output 1: one-clock pulse on the last clock of a machine cycle's final beat.

## Operation
- States: IDLE, RUN, HALT. Reset forces IDLE, and the beat register to W1. Reset outputs: all w/t = 0, `running` = 0, `cyc_end` = 0. w1 reads 0 in IDLE.
- IDLE: if `qd` = 1, go to RUN at W1/T1. Otherwise hold.
- RUN: the phase counter steps T1 → T2 → T3, each phase lasting PH_LEN clocks. The last clock of T3 is the beat boundary (BB).
- Next beat at BB:
  - From W1: W1 if `short` = 1, else W2.
  - From W2: W3 if `long` = 1, else W1.
  - From W3: always W1.
- `short` is honoured only in W1 and `long` only in W2. If both are high in W1, `short` wins.
- `stop` is sampled only at BB. If it is 1, go to HALT with the beat register already advanced to the next beat; the next phase is T1.
- HALT: t1..t3 = 0, and w1..w3 show the pending beat so the controller decodes it. When `qd` = 1, go to RUN at pending beat/T1. `stop` is ignored while in HALT.
- `qd` during RUN is ignored.
- `cyc_end` = 1 on the BB clock when the next beat is W1, whether or not `stop` is also set.
- `rst` mid-beat or in HALT aborts immediately to IDLE. No partial beat completes.
- Inputs `short`, `long`, `stop` may be combinational functions of w/t outputs. There is no path from them to outputs within the same clock, so there is no loop.

## Timing
- All outputs are registered.
- `qd` at clock n (IDLE/HALT) → `t1` and the beat level high from clock n+1.
- In RUN:
  - T1 occupies clocks [k, k+PH_LEN).
  - T2 occupies [k+PH_LEN, k+2·PH_LEN).
  - T3 occupies [k+2·PH_LEN, k+3·PH_LEN).
- BB is clock k+3·PH_LEN−1. The next beat's T1 (or HALT) starts at clock k+3·PH_LEN.
- The T3 falling edge coincides with the beat change. The controller's end-of-T3 updates see the beat that is ending.
- Machine cycle length: 1, 2 or 3 beats = 3, 6 or 9 ·PH_LEN clocks.

## Configuration
- `TIMING_STEP_EN` defined:
  - Adds input `step` (1 bit).
  - When `step` = 1 at a BB whose next beat is W1, go to HALT with pending W1. This executes exactly one machine cycle per `qd`.
  - `stop` keeps its normal effect.
- `TIMING_STEP_EN` undefined: the `step` port is absent and the block behaves as if `step` = 0.

## Test plan
- Reset/idle, PH_LEN = 1: assert `rst` 2 clocks → all outputs 0. With no `qd` for 10 clocks, outputs stay 0.
- Default 2-beat cycle: `qd` pulse, `short`/`long`/`stop` = 0.
  - Expect w1 for 3 clocks, then w2 for 3 clocks, then w1 again.
  - t1/t2/t3 rotate each clock.
  - `cyc_end` pulses on the 6th clock.
- Short and long:
  - `short` = 1 during W1 → W1 repeats, and `cyc_end` pulses every 3 clocks.
  - `long` = 1 during W2 → W1, W2, W3 sequence; `cyc_end` on the 9th clock.
  - `short` = `long` = 1 in W1 → next beat is W1.
- Stop/resume:
  - `stop` = 1 during W1 → after T3, t = 0, w2 = 1 held, `running` = 0.
  - `qd` 5 clocks later → W2/T1 on the next clock.
- Reset mid-operation: `rst` during W2/T2 → next clock is IDLE with all outputs 0. A later `qd` restarts at W1/T1.
- PH_LEN = 2 (and, with `TIMING_STEP_EN`, `step` = 1):
  - Each phase lasts 2 clocks and a beat lasts 6.
  - With `step` = 1, the block halts with w1 = 1 after each completed machine cycle until the next `qd`.
